ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 16, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 15, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 32768, number of words (DEPTH <= 2**ADDR_W).
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero-fill the array after reset.
REQ-005 SHALL have parameter CLEAR_VAL, default 0, WORD_W-bit fill value.
REQ-006 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port req_valid  in  1  request present.
REQ-009 SHALL have port req_ready  out  1  request can be accepted this cycle.
REQ-010 SHALL have port req_we  in  1  1 = write, 0 = read.
REQ-011 SHALL have port req_addr  in  ADDR_W  word address.
REQ-012 SHALL have port req_wdata  in  WORD_W  write data.
REQ-013 SHALL have port req_be  in  WORD_W/8  byte-lane write enables; bit i gates bits [8i+7:8i].
REQ-014 SHALL have port rsp_valid  out  1  one-cycle response strobe.
REQ-015 SHALL have port rsp_rdata  out  WORD_W  read data; 0 for writes and errors.
REQ-016 SHALL have port rsp_err  out  1  address >= DEPTH; qualified by rsp_valid.
REQ-017 SHALL have port init_busy  out  1  clear sequence in progress.

Function
REQ-018 SHALL implement FSM states INIT and RUN; after reset: INIT if CLEAR_ON_RESET=1, else RUN.
REQ-019 In INIT, SHALL write CLEAR_VAL (all lanes) to address clr_cnt each cycle, clr_cnt 0..DEPTH-1; go to RUN the cycle after writing DEPTH-1.
REQ-020 init_busy SHALL be 1 exactly while state==INIT; req_ready SHALL be 0 in INIT and 1 in RUN.
REQ-021 A request SHALL be accepted on a rising edge with req_valid && req_ready; one request per cycle, no bubbles.
REQ-022 Accepted write with addr < DEPTH SHALL update only lanes with req_be[i]=1 at that edge; req_be=0 is a legal no-op write.
REQ-023 Every accepted request SHALL yield rsp_valid=1 in exactly the next cycle (latency 1), writes included.
REQ-024 Read response SHALL carry mem[addr] as of before the accepting edge merged with no same-edge write (single port: one access per cycle).
REQ-025 Read one cycle after a write to the same address SHALL return the newly written lanes.
REQ-026 Accepted request with addr >= DEPTH SHALL not modify memory and SHALL respond rsp_err=1, rsp_rdata=0.
REQ-027 rsp_valid SHALL be 0 when no request was accepted in the previous cycle; no response backpressure exists.
REQ-028 Address arithmetic SHALL not wrap: addresses >= DEPTH are errors, never aliased.

Reset
REQ-029 On rst_n low (asynchronous): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clr_cnt=0, init_busy=CLEAR_ON_RESET, state=INIT/RUN per REQ-018.
REQ-030 Reset asserted mid-INIT SHALL abort the fill; the next INIT restarts at address 0.
REQ-031 Reset asserted with a response pending SHALL drop the response.
REQ-032 Array contents SHALL not be reset by rst_n; only the INIT sequence initialises them.

Structure
REQ-033 Package ram_pkg SHALL hold the FSM state type (INIT, RUN) and default WORD_W/ADDR_W/DEPTH constants.
REQ-034 Storage SHALL be sub-module ram_array: synchronous byte-enabled write, registered read, no reset, inferable as block RAM.
REQ-035 ram_ctrl SHALL own FSM, clear counter, range check, and response registers.

Verification
REQ-036 Reset, CLEAR_ON_RESET=1, DEPTH=16 -> init_busy=1 for 16 cycles, then req_ready=1; reads of 0..15 all return 0x0000.
REQ-037 Write 0x1234 to 5 with be=2'b11, then write 0xAB00 with be=2'b10, then read 5 -> rsp_rdata=0xAB34, rsp_valid one cycle after each accept.
REQ-038 Back-to-back write 0x00FF to 3 then read 3 on consecutive cycles -> read response 0x00FF.
REQ-039 DEPTH=16, ADDR_W=5: write 0xFFFF to 20, then read 20 -> both responses rsp_err=1, rdata=0; read 4 -> unchanged.
REQ-040 Assert rst_n low at clr_cnt=7 of INIT -> outputs at reset values immediately; after release init_busy lasts full DEPTH cycles.
REQ-041 CLEAR_ON_RESET=0 -> req_ready=1 in the first cycle after reset release, init_busy never asserted.

Source files
------------

// File: rtl/ram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_pkg : FSM state type and default geometry shared by the ram_ctrl slice
// rev 1.0
// ----------------------------------------------------------------------------
package ram_pkg;

   localparam int DEF_WORD_W = 16;
   localparam int DEF_ADDR_W = 15;
   localparam int DEF_DEPTH  = 32768;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_ctrl_if : request/response bus between a requester and ram_ctrl
// rev 1.0
// ----------------------------------------------------------------------------
interface ram_ctrl_if
   import ram_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [WORD_W-1:0]     req_wdata;
   logic [WORD_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic [WORD_W-1:0]     rsp_rdata;
   logic                  rsp_err;
   logic                  init_busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
   );

endinterface
`default_nettype wire

// File: rtl/ram_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_array : single-port storage, byte-enabled write, registered read, no reset
// rev 1.0
// ----------------------------------------------------------------------------
module ram_array
   import ram_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [WORD_W/8-1:0] be,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [WORD_W-1:0]   wdata,
   output logic [WORD_W-1:0]   rdata
);

   localparam int LANES = WORD_W / 8;

   logic [WORD_W-1:0] mem_q [0:DEPTH-1];
   logic [WORD_W-1:0] rdata_q;

   // The caller only enables the port for in-range addresses.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < LANES; i++) begin
               if (be[i]) begin
                  mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ram_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_ctrl : RAM controller with power-up clear, range check and 1-cycle response
// rev 1.0
// ----------------------------------------------------------------------------
module ram_ctrl
   import ram_pkg::*;
#(
   parameter int                WORD_W         = DEF_WORD_W,
   parameter int                ADDR_W         = DEF_ADDR_W,
   parameter int                DEPTH          = DEF_DEPTH,
   parameter bit                CLEAR_ON_RESET = 1'b1,
   parameter logic [WORD_W-1:0] CLEAR_VAL      = '0
) (
   input logic       clk,
   input logic       rst_n,
   ram_ctrl_if.slave bus
);

   localparam int                LANES       = WORD_W / 8;
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT   = (ADDR_W + 1)'(DEPTH);
   localparam state_t            RESET_STATE = CLEAR_ON_RESET ? INIT : RUN;

   state_t              state_q,     state_d;
   logic [ADDR_W-1:0]   clr_cnt_q,   clr_cnt_d;
   logic                req_ready_q, req_ready_d;
   logic                init_busy_q, init_busy_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q,   rsp_err_d;
   logic                rsp_rd_q,    rsp_rd_d;

   logic                accept;
   logic                in_range;
   logic                mem_en;
   logic                mem_we;
   logic [LANES-1:0]    mem_be;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WORD_W-1:0]   mem_wdata;
   logic [WORD_W-1:0]   mem_rdata;

   always_comb begin
      accept    = bus.req_valid && req_ready_q;
      // Compare one bit wider so no address can alias onto a valid word.
      in_range  = {1'b0, bus.req_addr} < DEPTH_EXT;

      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;

      mem_en    = accept && in_range;
      mem_we    = bus.req_we;
      mem_be    = bus.req_be;
      mem_addr  = bus.req_addr;
      mem_wdata = bus.req_wdata;

      case (state_q)
         INIT: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = clr_cnt_q;
            mem_wdata = CLEAR_VAL;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d   = RUN;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase

      req_ready_d = (state_d == RUN);
      init_busy_d = (state_d == INIT);
      rsp_valid_d = accept;
      rsp_err_d   = accept && !in_range;
      rsp_rd_d    = accept && in_range && !bus.req_we;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_STATE;
         clr_cnt_q   <= '0;
         req_ready_q <= 1'b0;
         init_busy_q <= CLEAR_ON_RESET;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rd_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         req_ready_q <= req_ready_d;
         init_busy_q <= init_busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rd_q    <= rsp_rd_d;
      end
   end

   ram_array #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .en    (mem_en),
      .we    (mem_we),
      .be    (mem_be),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // Read data is only exposed for in-range reads; writes and errors return zero.
   assign bus.rsp_rdata = rsp_rd_q ? mem_rdata : '0;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.req_ready = req_ready_q;
   assign bus.init_busy = init_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ram_ctrl : randomized self-checking bench against a word-array model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_ram_ctrl;

   localparam int WW    = 16;
   localparam int AW    = 5;
   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   ram_ctrl_if #(.WORD_W(WW), .ADDR_W(AW)) bus0 ();
   ram_ctrl_if #(.WORD_W(WW), .ADDR_W(AW)) bus1 ();

   ram_ctrl #(
      .WORD_W(WW), .ADDR_W(AW), .DEPTH(DEPTH),
      .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(16'h0000)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );

   ram_ctrl #(
      .WORD_W(WW), .ADDR_W(AW), .DEPTH(DEPTH),
      .CLEAR_ON_RESET(1'b0), .CLEAR_VAL(16'h0000)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   logic [WW-1:0] mem_m [DEPTH];
   int            init_left;
   int            edges1;
   int            n_checks;
   int            n_fail;
   int            busy_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock of traffic on bus0; expectations come from the word-array model.
   task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [WW-1:0] wd, input logic [1:0] be);
      logic          acc;
      logic          err;
      logic [WW-1:0] exp_rd;
      bus0.req_valid = v;
      bus0.req_we    = we;
      bus0.req_addr  = a;
      bus0.req_wdata = wd;
      bus0.req_be    = be;
      check("req_ready", 32'(bus0.req_ready), 32'(init_left == 0));
      check("nc_ready",  32'(bus1.req_ready), 32'(edges1 > 0));
      check("nc_busy",   32'(bus1.init_busy), 32'd0);
      acc    = v && (init_left == 0);
      err    = int'(a) >= DEPTH;
      exp_rd = '0;
      if (acc && !err) begin
         if (we) begin
            if (be[0]) mem_m[a[3:0]][7:0]  = wd[7:0];
            if (be[1]) mem_m[a[3:0]][15:8] = wd[15:8];
         end else begin
            exp_rd = mem_m[a[3:0]];
         end
      end
      @(posedge clk);
      #1;
      if (init_left > 0) init_left--;
      edges1++;
      check("rsp_valid", 32'(bus0.rsp_valid), 32'(acc));
      if (acc) begin
         check("rsp_err",   32'(bus0.rsp_err),   32'(err));
         check("rsp_rdata", 32'(bus0.rsp_rdata), 32'(exp_rd));
      end
      check("init_busy", 32'(bus0.init_busy), 32'(init_left > 0));
      bus0.req_valid = 1'b0;
   endtask

   // Called just after a rising edge; asserts reset between edges.
   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_ready",     32'(bus0.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(bus0.rsp_rdata), 32'd0);
      check("rst_rsp_err",   32'(bus0.rsp_err),   32'd0);
      check("rst_init_busy", 32'(bus0.init_busy), 32'd1);
      check("rst_nc_ready",  32'(bus1.req_ready), 32'd0);
      check("rst_nc_busy",   32'(bus1.init_busy), 32'd0);
      bus0.req_valid = 1'b0;
      bus1.req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      init_left = DEPTH;
      edges1    = 0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
   endtask

   task automatic count_init(input logic poke);
      busy_cnt = 0;
      for (int k = 0; k < 40 && bus0.init_busy; k++) begin
         cycle(poke, 1'b1, AW'($urandom_range(0, DEPTH - 1)), 16'($urandom), 2'b11);
         busy_cnt++;
      end
      check("init_len", 32'(busy_cnt), 32'(DEPTH));
   endtask

   task automatic random_traffic(input int n);
      for (int k = 0; k < n; k++) begin
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 19)),
               16'($urandom), 2'($urandom));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      init_left = DEPTH;
      edges1   = 0;
      bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
      bus0.req_wdata = '0;   bus0.req_be = '0;
      bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
      bus1.req_wdata = '0;   bus1.req_be = '0;

      @(posedge clk);
      #1;
      apply_reset();
      count_init(1'b1);
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, AW'(i), 16'h0, 2'b00);

      cycle(1'b1, 1'b1, 5'd5, 16'h1234, 2'b11);
      cycle(1'b1, 1'b1, 5'd5, 16'hAB00, 2'b10);
      cycle(1'b1, 1'b0, 5'd5, 16'h0000, 2'b00);
      check("merge_ab34", 32'(bus0.rsp_rdata), 32'h0000AB34);

      cycle(1'b1, 1'b1, 5'd3, 16'h00FF, 2'b11);
      cycle(1'b1, 1'b0, 5'd3, 16'h0000, 2'b00);
      cycle(1'b1, 1'b1, 5'd7, 16'h5A5A, 2'b00);
      cycle(1'b1, 1'b0, 5'd7, 16'h0000, 2'b00);

      cycle(1'b1, 1'b1, 5'd20, 16'hFFFF, 2'b11);
      cycle(1'b1, 1'b0, 5'd20, 16'h0000, 2'b00);
      cycle(1'b1, 1'b0, 5'd4,  16'h0000, 2'b00);
      check("no_alias_4", 32'(bus0.rsp_rdata), 32'h0);

      bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 5'd9;
      bus1.req_wdata = 16'hBEEF; bus1.req_be = 2'b11;
      cycle(1'b0, 1'b0, 5'd0, 16'h0, 2'b00);
      check("nc_wr_valid", 32'(bus1.rsp_valid), 32'd1);
      check("nc_wr_rdata", 32'(bus1.rsp_rdata), 32'd0);
      bus1.req_we = 1'b0;
      cycle(1'b0, 1'b0, 5'd0, 16'h0, 2'b00);
      check("nc_rd_rdata", 32'(bus1.rsp_rdata), 32'h0000BEEF);
      bus1.req_valid = 1'b0;
      cycle(1'b0, 1'b0, 5'd0, 16'h0, 2'b00);
      check("nc_idle_valid", 32'(bus1.rsp_valid), 32'd0);

      random_traffic(300);

      cycle(1'b1, 1'b1, 5'd6, 16'hC3C3, 2'b11);
      cycle(1'b1, 1'b0, 5'd6, 16'h0000, 2'b00);
      apply_reset();
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 5'd0, 16'h0, 2'b00);
      apply_reset();
      count_init(1'b0);
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, AW'(i), 16'h0, 2'b00);

      bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 5'd9;
      cycle(1'b0, 1'b0, 5'd0, 16'h0, 2'b00);
      check("nc_retain", 32'(bus1.rsp_rdata), 32'h0000BEEF);
      bus1.req_valid = 1'b0;

      random_traffic(200);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
